// File: rtl/z_result_stage.sv
// rtl/z_result_stage.sv - FIFO buffering ALU results as Z with HI/LO update on MULT/DIV retirement
// Optional head-entry flags are built only when Z_FLAGS_EN is defined.
module z_result_stage #(
  parameter int DEPTH = 2,
  parameter int AW    = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [63:0]   alu_out,
  input  logic [4:0]    op_code,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [31:0]   z_lo,
  output logic [31:0]   z_hi,
  output logic [4:0]    z_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   hi_reg,
  output logic [31:0]   lo_reg,
  output logic [AW:0]   count,
  output logic          zero_flag,
  output logic          neg_flag
);

  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
  localparam logic [4:0]  OP_MULT    = 5'b01111;
  localparam logic [4:0]  OP_DIV     = 5'b10000;

  logic [63:0]   mem_data [DEPTH];
  logic [4:0]    mem_op   [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [63:0]   head;

  // Handshake depends only on registered occupancy, so no ready/valid loop exists.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head = mem_data[rd_ptr];
  assign z_hi = head[63:32];
  assign z_lo = head[31:0];
  assign z_op = mem_op[rd_ptr];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_op[i]   <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= alu_out;
        mem_op[wr_ptr]   <= op_code;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      hi_reg <= '0;
      lo_reg <= '0;
    end else if (pop && (z_op == OP_MULT || z_op == OP_DIV)) begin
      hi_reg <= z_hi;
      lo_reg <= z_lo;
    end
  end

`ifdef Z_FLAGS_EN
  assign zero_flag = (head == 64'd0) & out_valid;
  assign neg_flag  = z_lo[31] & out_valid;
`else
  assign zero_flag = 1'b0;
  assign neg_flag  = 1'b0;
`endif

endmodule

// File: tb/tb_z_result_stage.sv
// tb/tb_z_result_stage.sv - scoreboard bench for z_result_stage
module tb_z_result_stage;

  localparam int DEPTH = 2;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_MULT = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [63:0] alu_out = '0;
  logic [4:0]  op_code = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] z_lo, z_hi, hi_reg, lo_reg;
  logic [4:0]  z_op;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  count;
  logic        zero_flag, neg_flag;

  int checks = 0;
  int errors = 0;

  logic [68:0] exp_q[$];
  int          mcount = 0;
  logic [31:0] mhi = '0, mlo = '0;

  z_result_stage #(.DEPTH(DEPTH), .AW(1)) dut (
    .clk(clk), .clr(clr), .alu_out(alu_out), .op_code(op_code),
    .in_valid(in_valid), .in_ready(in_ready), .z_lo(z_lo), .z_hi(z_hi),
    .z_op(z_op), .out_valid(out_valid), .out_ready(out_ready),
    .hi_reg(hi_reg), .lo_reg(lo_reg), .count(count),
    .zero_flag(zero_flag), .neg_flag(neg_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus just after a rising edge, then advance past the next edge.
  task automatic step(input logic iv, input logic [63:0] data, input logic [4:0] op, input logic ordy);
    in_valid  = iv;
    alu_out   = data;
    op_code   = op;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  // Monitor/scoreboard: compares state mid-cycle, then retires the modelled edge.
  always @(negedge clk) begin
    logic [68:0] e;
    logic        mpush, mpop, exp_zero, exp_neg;
    if (clr) begin
      exp_q.delete();
      mcount = 0;
      mhi = '0;
      mlo = '0;
    end else begin
      check("in_ready", 64'(in_ready), 64'(mcount != DEPTH));
      check("out_valid", 64'(out_valid), 64'(mcount != 0));
      check("count", 64'(count), 64'(mcount));
      check("hi_reg", 64'(hi_reg), 64'(mhi));
      check("lo_reg", 64'(lo_reg), 64'(mlo));
      exp_zero = 1'b0;
      exp_neg  = 1'b0;
`ifdef Z_FLAGS_EN
      if (mcount != 0 && exp_q.size() > 0) begin
        exp_zero = (exp_q[0][63:0] == 64'd0);
        exp_neg  = exp_q[0][31];
      end
`endif
      check("zero_flag", 64'(zero_flag), 64'(exp_zero));
      check("neg_flag", 64'(neg_flag), 64'(exp_neg));
      mpop  = (mcount != 0) && out_ready;
      mpush = in_valid && (mcount != DEPTH);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_output", 64'(z_op), 64'h1f);
          errors++;
          $display("FAIL unexpected_output: got entry with empty scoreboard expected none");
        end else begin
          e = exp_q.pop_front();
          check("z_hi", 64'(z_hi), 64'(e[63:32]));
          check("z_lo", 64'(z_lo), 64'(e[31:0]));
          check("z_op", 64'(z_op), 64'(e[68:64]));
          if (e[68:64] == OP_MULT || e[68:64] == OP_DIV) begin
            mhi = e[63:32];
            mlo = e[31:0];
          end
        end
      end
      if (mpush) exp_q.push_back({op_code, alu_out});
      mcount = mcount + int'(mpush) - int'(mpop);
    end
  end

  initial begin
    #2 clr = 1'b1;
    #1;
    check("rst_count", 64'(count), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_z", {z_hi, z_lo}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1 clr = 1'b0;

    // Push ADD 5 with no consumer: visible after one edge.
    step(1'b1, 64'h5, OP_ADD, 1'b0);
    in_valid = 1'b0;
    check("t2_out_valid", 64'(out_valid), 64'd1);
    check("t2_z_lo", 64'(z_lo), 64'd5);
    check("t2_z_op", 64'(z_op), 64'(OP_ADD));
    check("t2_count", 64'(count), 64'd1);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t2_drained", 64'(count), 64'd0);

    // Fill: the third push while full is dropped.
    step(1'b1, 64'h1111_0000_0000_0001, OP_ADD, 1'b0);
    step(1'b1, 64'h2222_0000_0000_0002, OP_ADD, 1'b0);
    check("t3_full_in_ready", 64'(in_ready), 64'd0);
    step(1'b1, 64'h3333_0000_0000_0003, OP_ADD, 1'b0);
    check("t3_full_count", 64'(count), 64'd2);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t3_head2", 64'(z_lo), 64'd2);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t3_empty", 64'(out_valid), 64'd0);

    // Simultaneous push/pop at count=1 across pointer wrap.
    step(1'b1, 64'h10, OP_ADD, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 64'(32'h10 + i), OP_ADD, 1'b1);
      check("t4_count", 64'(count), 64'd1);
      check("t4_head", 64'(z_lo), 64'(32'h10 + i));
    end
    step(1'b0, 64'h0, 5'd0, 1'b1);

    // HI/LO update only on MULT/DIV retirement.
    step(1'b1, 64'h0000_0001_FFFF_FFFE, OP_MULT, 1'b0);
    step(1'b1, 64'h7, OP_ADD, 1'b0);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t5_hi", 64'(hi_reg), 64'h1);
    check("t5_lo", 64'(lo_reg), 64'hFFFF_FFFE);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t5_hi_hold", 64'(hi_reg), 64'h1);
    check("t5_lo_hold", 64'(lo_reg), 64'hFFFF_FFFE);
    step(1'b1, 64'h0000_0003_0000_0004, OP_DIV, 1'b0);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    check("t5_div_hi", 64'(hi_reg), 64'h3);

    // Flags on zero and negative heads.
    step(1'b1, 64'h0, OP_ADD, 1'b0);
`ifdef Z_FLAGS_EN
    check("t6_zero", 64'(zero_flag), 64'd1);
`else
    check("t6_zero", 64'(zero_flag), 64'd0);
`endif
    step(1'b0, 64'h0, 5'd0, 1'b1);
    step(1'b1, 64'h8000_0000, OP_ADD, 1'b0);
`ifdef Z_FLAGS_EN
    check("t6_neg", 64'(neg_flag), 64'd1);
`else
    check("t6_neg", 64'(neg_flag), 64'd0);
`endif
    step(1'b0, 64'h0, 5'd0, 1'b1);

    // Mid-cycle clear with two entries queued.
    step(1'b1, 64'hA, OP_MULT, 1'b0);
    step(1'b1, 64'hB, OP_ADD, 1'b0);
    in_valid = 1'b0;
    #2 clr = 1'b1;
    #1;
    check("t1_count", 64'(count), 64'd0);
    check("t1_out_valid", 64'(out_valid), 64'd0);
    check("t1_in_ready", 64'(in_ready), 64'd1);
    check("t1_hilo", {hi_reg, lo_reg}, 64'd0);
    @(posedge clk);
    #1 clr = 1'b0;
    step(1'b1, 64'h9, OP_ADD, 1'b0);
    check("t1_post_count", 64'(count), 64'd1);
    check("t1_post_z_lo", 64'(z_lo), 64'd9);
    step(1'b0, 64'h0, 5'd0, 1'b1);
    step(1'b0, 64'h0, 5'd0, 1'b0);

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
